// File: rtl/psdram_pkg.sv
// Definitions shared by the PSDRAM frame writer and the VGA scan-out reader:
// write-cycle state encoding, frame geometry and RGB332 pixel layout.
package psdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } wr_state_t;

  localparam int PSDRAM_LINE_WORDS  = 640;
  localparam int PSDRAM_VLINES      = 480;
  localparam int PSDRAM_FRAME_WORDS = PSDRAM_LINE_WORDS * PSDRAM_VLINES;
  localparam int PSDRAM_ADDR_W      = 23;

  // Two RGB332 pixels per 16-bit word, even pixel in the upper byte.
  localparam int PIX_EVEN_MSB = 15;
  localparam int PIX_EVEN_LSB = 8;
  localparam int PIX_ODD_MSB  = 7;
  localparam int PIX_ODD_LSB  = 0;
  localparam int RGB_R_MSB    = 7;
  localparam int RGB_R_LSB    = 5;
  localparam int RGB_G_MSB    = 4;
  localparam int RGB_G_LSB    = 2;
  localparam int RGB_B_MSB    = 1;
  localparam int RGB_B_LSB    = 0;

  function automatic int unsigned frame_word_addr(input int unsigned line,
                                                  input int unsigned word,
                                                  input int unsigned stride);
    return line * stride + word;
  endfunction

endpackage

// File: rtl/psdram_addr_counter.sv
// Frame word counter: clear has priority over increment; wrapping from the last
// word loads 0 and raises frame_done for the following cycle.
module psdram_addr_counter
  import psdram_pkg::*;
#(
  parameter int FRAME_WORDS = PSDRAM_FRAME_WORDS,
  parameter int ADDR_W      = PSDRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        if (count == LAST) begin
          count      <= '0;
          frame_done <= 1'b1;
        end else begin
          count <= count + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/psdram_frame_writer.sv
// Streams RGB332 pixel words into the PSDRAM frame buffer, one word per WR_CYCLES+3 clocks;
// pix_ready drops for the whole write cycle. PSDRAM_BYTE_WRITE_EN adds per-byte enables.
module psdram_frame_writer
  import psdram_pkg::*;
#(
  parameter int LINE_WORDS = PSDRAM_LINE_WORDS,
  parameter int VLINES     = PSDRAM_VLINES,
  parameter int WR_CYCLES  = 7,
  parameter int ADDR_W     = PSDRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [15:0]       pix_data,
`ifdef PSDRAM_BYTE_WRITE_EN
  input  logic [1:0]        pix_be,
`endif
  input  logic              frame_start,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] MemAdr,
  output logic [15:0]       MemDataOut,
  output logic              MemDataOe,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamCE,
  output logic              RamLB,
  output logic              RamUB,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRAME_WORDS = LINE_WORDS * VLINES;
  localparam int WCW         = $clog2(WR_CYCLES + 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(WR_CYCLES - 1);

  wr_state_t         state, state_nxt;
  logic [WCW-1:0]    wcnt, wcnt_nxt;
  logic              frame_pend;
  logic              xfer;
  logic              cnt_clr, cnt_inc;
  logic [ADDR_W-1:0] count;
  logic [1:0]        be_cur;
  logic [1:0]        lane_n;
  logic              wr_nxt, ce_nxt, oe_nxt, ub_nxt, lb_nxt;

`ifdef PSDRAM_BYTE_WRITE_EN
  logic [1:0] be_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      be_q <= 2'b11;
    end else if (xfer) begin
      be_q <= pix_be;
    end
  end

  assign be_cur = xfer ? pix_be : be_q;
  assign lane_n = ~be_cur;
`else
  assign be_cur = 2'b11;
  assign lane_n = 2'b00;
`endif

  assign pix_ready = (state == ST_IDLE) && bus_grant;
  assign bus_req   = (state != ST_IDLE) || pix_valid;
  assign busy      = (state != ST_IDLE);
  assign xfer      = pix_valid && pix_ready;
  assign MemOE     = 1'b1;

  // A frame_start seen while busy is honoured when the current word retires.
  assign cnt_clr = ((state == ST_IDLE) && frame_start) ||
                   ((state == ST_HOLD) && (frame_pend || frame_start));
  assign cnt_inc = (state == ST_HOLD);

  psdram_addr_counter #(
    .FRAME_WORDS(FRAME_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_addr_counter (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .count     (count),
    .frame_done(frame_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      frame_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state == ST_HOLD) begin
        frame_pend <= 1'b0;
      end else if (frame_start && (state != ST_IDLE)) begin
        frame_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      ST_IDLE:  if (xfer) state_nxt = ST_SETUP;
      ST_SETUP: begin
        state_nxt = ST_WRITE;
        wcnt_nxt  = '0;
      end
      ST_WRITE: begin
        if (wcnt == W_LAST) state_nxt = ST_HOLD;
        else                wcnt_nxt  = wcnt + WCW'(1);
      end
      ST_HOLD:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    // Bus pins are registered, so they are decoded from the state being entered.
    wr_nxt = 1'b1;
    ce_nxt = 1'b1;
    oe_nxt = 1'b0;
    ub_nxt = 1'b0;
    lb_nxt = 1'b0;
    if (state_nxt != ST_IDLE) begin
      ce_nxt = ~|be_cur;
      oe_nxt = 1'b1;
      wr_nxt = (state_nxt != ST_WRITE);
      ub_nxt = lane_n[1];
      lb_nxt = lane_n[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MemWR      <= 1'b1;
      RamCE      <= 1'b1;
      MemDataOe  <= 1'b0;
      RamUB      <= 1'b0;
      RamLB      <= 1'b0;
      MemAdr     <= '0;
      MemDataOut <= '0;
    end else begin
      MemWR     <= wr_nxt;
      RamCE     <= ce_nxt;
      MemDataOe <= oe_nxt;
      RamUB     <= ub_nxt;
      RamLB     <= lb_nxt;
      if (xfer) begin
        MemAdr     <= frame_start ? '0 : count;
        MemDataOut <= pix_data;
      end
    end
  end

endmodule

// File: tb/tb_psdram_frame_writer.sv
// Bench for psdram_frame_writer with a two-line frame so the wrap is reachable quickly.
module tb_psdram_frame_writer;

  localparam int LW     = 640;
  localparam int VL     = 2;
  localparam int WRC    = 7;
  localparam int AW     = 23;
  localparam int FW     = LW * VL;
  localparam int PERIOD = WRC + 3;
  localparam int TCLK   = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pix_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          bus_grant = 1'b0;
  logic [15:0]   pix_data = 16'h0;
  logic [1:0]    be_drv = 2'b11;
  logic          pix_ready, bus_req, MemDataOe, MemOE, MemWR, RamCE, RamLB, RamUB, busy, frame_done;
  logic [AW-1:0] MemAdr;
  logic [15:0]   MemDataOut;

  int errors = 0;
  int checks = 0;

  always #(TCLK/2) clk = ~clk;

  psdram_frame_writer #(.LINE_WORDS(LW), .VLINES(VL), .WR_CYCLES(WRC), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
`ifdef PSDRAM_BYTE_WRITE_EN
    .pix_be     (be_drv),
`endif
    .frame_start(frame_start),
    .bus_req    (bus_req),
    .bus_grant  (bus_grant),
    .MemAdr     (MemAdr),
    .MemDataOut (MemDataOut),
    .MemDataOe  (MemDataOe),
    .MemOE      (MemOE),
    .MemWR      (MemWR),
    .RamCE      (RamCE),
    .RamLB      (RamLB),
    .RamUB      (RamUB),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // PSDRAM: a word is committed on the rising edge of MemWR while selected.
  logic [15:0] mem [int];
  always @(posedge MemWR) begin : psdram_model
    logic [15:0] w;
    if (RamCE === 1'b0) begin
      w = mem.exists(int'(MemAdr)) ? mem[int'(MemAdr)] : 16'h0000;
      if (!RamUB) w[15:8] = MemDataOut[15:8];
      if (!RamLB) w[7:0]  = MemDataOut[7:0];
      mem[int'(MemAdr)] = w;
    end
  end

  function automatic logic [15:0] rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'hxxxx;
  endfunction

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 263) ^ 16'h5A3C;
  endfunction

  // Reference: clocks elapsed since acceptance (0 = idle) plus the frame word pointer.
  int          phase = 0;
  int          m_cnt = 0;
  bit          m_pend = 1'b0;
  bit          fd_exp = 1'b0;
  int          exp_addr = 0;
  logic [15:0] exp_data = 16'h0;
  logic [1:0]  exp_be = 2'b11;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase  = 0;
      m_cnt  = 0;
      m_pend = 1'b0;
      fd_exp = 1'b0;
    end else begin
      fd_exp = 1'b0;
      if (phase == 0) begin
        if (frame_start) m_cnt = 0;
        if (pix_valid && bus_grant) begin
          exp_addr = m_cnt;
          exp_data = pix_data;
          exp_be   = be_drv;
          phase    = 1;
        end
      end else if (phase == PERIOD - 1) begin
        if (m_pend || frame_start) begin
          m_cnt  = 0;
          m_pend = 1'b0;
        end else if (m_cnt == FW - 1) begin
          m_cnt  = 0;
          fd_exp = 1'b1;
        end else begin
          m_cnt++;
        end
        phase = 0;
      end else begin
        if (frame_start) m_pend = 1'b1;
        phase++;
      end
    end
  end

  logic [9:0] ev, av;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      ev = {phase != 0, !(phase >= 2 && phase <= WRC + 1), !(phase != 0 && exp_be != 2'b00),
            phase != 0, (phase != 0) ? ~exp_be : 2'b00, phase == 0 && bus_grant,
            phase != 0 || pix_valid, 1'b1, fd_exp};
      av = {busy, MemWR, RamCE, MemDataOe, RamUB, RamLB, pix_ready, bus_req, MemOE, frame_done};
      chk("ctrl{busy,wr,ce,doe,ub,lb,rdy,req,oe,fd}", {54'd0, av}, {54'd0, ev});
      if (phase != 0) begin
        chk("MemAdr", 64'(MemAdr), 64'(exp_addr));
        chk("MemDataOut", 64'(MemDataOut), 64'(exp_data));
      end
    end
  end

  int wr_low = 0;
  int fd_count = 0;
  int fd_adr = -1;
  always @(negedge clk) begin
    if (reset && !MemWR) wr_low++;
    if (reset && frame_done) begin
      fd_count++;
      fd_adr = int'(MemAdr);
    end
  end

  task automatic send(input logic [15:0] d, input logic fs, output time at);
    int t;
    @(negedge clk);
    pix_valid   = 1'b1;
    pix_data    = d;
    frame_start = fs;
    t = 0;
    #1;
    while (!pix_ready && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("accept_within_budget", 64'(pix_ready), 64'd1);
    @(posedge clk);
    at = $time;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    time t, tp;
    int bad;
    logic [15:0] old2;

    #23;
    chk("reset_ctrl", {54'd0, MemOE, MemWR, RamCE, RamLB, RamUB, MemDataOe, pix_ready, bus_req,
                       busy, frame_done}, {54'd0, 10'b1110000000});
    chk("reset_adr", 64'(MemAdr), 64'd0);
    chk("reset_dat", 64'(MemDataOut), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Valid without grant: request but no cycle.
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = 16'h1111;
    repeat (3) @(negedge clk);
    #1;
    chk("nogrant{req,rdy,busy,ce}", {60'd0, bus_req, pix_ready, busy, RamCE}, {60'd0, 4'b1001});
    @(negedge clk);
    pix_valid = 1'b0;
    bus_grant = 1'b1;
    #1;
    wr_low = 0;

    // Single word, then a second to time the re-acceptance.
    send(16'hE31C, 1'b0, tp);
    send(16'h0F0F, 1'b0, t);
    chk("reaccept_gap", 64'(t - tp), 64'(PERIOD * TCLK));
    chk("wr_low_cycles", 64'(wr_low), 64'd7);
    idle(12);
    chk("mem0_E31C", 64'(rd(0)), 64'h E31C);
    chk("mem1_0F0F", 64'(rd(1)), 64'h0F0F);

    // 641-word stream; first word carries frame_start so it lands at 0.
    bad = 0;
    for (int i = 0; i <= 640; i++) begin
      send(pat(i), i == 0, t);
      if (i > 0 && (t - tp) != PERIOD * TCLK) bad++;
      tp = t;
    end
    @(negedge clk);
    #1;
    chk("adr_word640", 64'(MemAdr), 64'd640);
    chk("stream_gaps_bad", 64'(bad), 64'd0);
    for (int i = 641; i <= 1234; i++) send(pat(i), 1'b0, t);
    repeat (3) @(negedge clk);
    frame_start = 1'b1;
    #1;
    chk("adr1234_in_write", 64'(MemAdr), 64'd1234);
    @(negedge clk);
    frame_start = 1'b0;
    send(16'hBEEF, 1'b0, t);
    idle(12);
    chk("mem640", 64'(rd(640)), 64'(pat(640)));
    chk("mem0_stream", 64'(rd(0)) == 64'(16'hBEEF) ? 64'd1 : 64'd0, 64'd1);
    chk("mem1234", 64'(rd(1234)), 64'(pat(1234)));
    chk("no_fd_on_restart", 64'(fd_count), 64'd0);
    chk("adr_after_restart", 64'(MemAdr), 64'd0);

    // Fill 1..FW-1 to hit the wrap.
    for (int i = 1; i < FW; i++) send(pat(i + 3000), 1'b0, t);
    idle(12);
    chk("fd_count_wrap", 64'(fd_count), 64'd1);
    chk("fd_after_last_adr", 64'(fd_adr), 64'(FW - 1));
    send(16'hC0DE, 1'b0, t);
    idle(12);
    chk("mem_last", 64'(rd(FW - 1)), 64'(pat(FW - 1 + 3000)));
    chk("mem0_after_wrap", 64'(rd(0)), 64'hC0DE);
    chk("fd_count_final", 64'(fd_count), 64'd1);

    // Grant withdrawn mid-write: cycle still completes (word goes to 1).
    send(16'h7777, 1'b0, t);
    repeat (3) @(negedge clk);
    bus_grant = 1'b0;
    idle(12);
    chk("grant_drop_write", 64'(rd(1)), 64'h7777);
    bus_grant = 1'b1;

    // Asynchronous reset during WRITE of address 2.
    send(16'h4444, 1'b0, t);
    repeat (3) @(negedge clk);
    bus_grant = 1'b0;
    pix_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid{wr,ce,oe,doe}", {60'd0, MemWR, RamCE, MemOE, MemDataOe}, {60'd0, 4'b1110});
    @(negedge clk);
    reset     = 1'b1;
    bus_grant = 1'b1;
    send(16'h1357, 1'b0, t);
    idle(12);
    chk("post_reset_adr0", 64'(rd(0)), 64'h1357);

`ifdef PSDRAM_BYTE_WRITE_EN
    be_drv = 2'b01;
    send(16'hABCD, 1'b0, t);
    idle(12);
    chk("be01_low_only", 64'(rd(1)), 64'h77CD);
    old2   = rd(2);
    be_drv = 2'b00;
    send(16'h9999, 1'b0, t);
    idle(12);
    chk("be00_no_write", 64'(rd(2)), 64'(old2));
    be_drv = 2'b11;
    send(16'h2468, 1'b0, t);
    idle(12);
    chk("be00_addr_advanced", 64'(rd(3)), 64'h2468);
`else
    old2 = 16'h0;
    send(16'h2468, 1'b0, t);
    idle(12);
    chk("next_after_reset", 64'(rd(1)) | 64'(old2), 64'h2468);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psdram_frame_writer.md
Name: psdram_frame_writer

Overview:
- Write-side counterpart of the VGA PSDRAM scan-out path: accepts packed RGB332 pixel words over a valid/ready stream and issues asynchronous write cycles to the cellular PSDRAM.
- Fills the frame buffer at word address line*LINE_WORDS + word index. The VGA reader fetches from the same layout.
- Shares the memory bus with the reader through a req/grant pair. The external arbiter muxes MemAdr/MemOE/MemWR/RamCE/RamLB/RamUB between the two.

Parameters:
- LINE_WORDS, 640, 16-bit words per line (stride)
- VLINES, 480, lines per frame
- WR_CYCLES, 7, clk cycles MemWR held low (7 × 10 ns ≥ 70 ns tWP)
- ADDR_W, 23, PSDRAM address width

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  writer can accept a word
- pix_data  in  16  [15:8] even pixel, [7:0] odd pixel, RGB332 each
- frame_start  in  1  pulse: next accepted word goes to address 0
- bus_req  out  1  request for the PSDRAM bus
- bus_grant  in  1  arbiter grant
- MemAdr  out  23  word address
- MemDataOut  out  16  write data
- MemDataOe  out  1  drive enable for the external data tristate
- MemOE  out  1  active-low output enable, always 1
- MemWR  out  1  active-low write enable
- RamCE  out  1  active-low chip enable
- RamLB  out  1  active-low lower-byte enable
- RamUB  out  1  active-low upper-byte enable
- busy  out  1  write cycle in progress
- frame_done  out  1  one-cycle pulse after the last word of a frame is written

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, MemOE=1, MemWR=1, RamCE=1, RamLB=0, RamUB=0, MemDataOe=0, MemAdr=0, MemDataOut=0, addr counter=0, pix_ready=0, bus_req=0, busy=0, frame_done=0, frame_start pending flag=0.
  - Reset mid-cycle aborts the write; the word in flight is undefined in memory.
- All memory-side outputs are registered.
- FRAME_WORDS = LINE_WORDS*VLINES = 307200.
- Address counter runs 0..FRAME_WORDS-1. MemAdr is the counter zero-extended to ADDR_W.
- bus_req = (state==IDLE && pix_valid) || state!=IDLE.
- pix_ready = (state==IDLE) && bus_grant.
- Transfer occurs on a rising edge with pix_valid && pix_ready: pix_data and the address are latched.
- State machine:
  - IDLE: RamCE=1, MemWR=1, MemDataOe=0. On transfer -> SETUP.
  - SETUP (1 cycle): RamCE=0, MemAdr and MemDataOut valid, MemDataOe=1, MemWR=1 -> WRITE.
  - WRITE (WR_CYCLES cycles, counter): MemWR=0, CE/address/data stable -> HOLD.
  - HOLD (1 cycle): MemWR=1, RamCE=0, data still driven (tDH) -> IDLE. Address counter increments on this edge.
- Throughput: one word per WR_CYCLES+3 clocks (10 clocks at default); pix_ready is low for WR_CYCLES+2.
- busy=1 in SETUP/WRITE/HOLD.
- Wrap-around: increment at FRAME_WORDS-1 loads 0, and frame_done pulses 1 cycle on the IDLE entry.
- frame_start handling:
  - In IDLE: counter cleared on that edge.
  - Coincident with a transfer: the accepted word is written at address 0.
  - While busy: sets a pending flag. The current write completes at its old address; HOLD then loads 0 instead of incrementing (no frame_done) and clears the flag.
- bus_grant falling mid-cycle is ignored; the cycle always completes. The arbiter only switches while bus_req=0 or in IDLE.
- pix_valid may drop without a transfer; there is no obligation to hold it.

Optional Feature:
- Macro: PSDRAM_BYTE_WRITE_EN
- Defined: adds input pix_be[1:0] (active-high, [1]=upper byte), latched at transfer. During SETUP/WRITE/HOLD, RamUB=~be[1] and RamLB=~be[0].
  - be==2'b00: the transfer is accepted and the address advances, but RamCE stays 1 for the whole cycle (no write).
- Undefined: no port; RamUB=RamLB=0 always.

Decomposition:
- Shared package psdram_pkg:
  - state encoding constants (IDLE/SETUP/WRITE/HOLD)
  - LINE_WORDS/VLINES/FRAME_WORDS defaults
  - ADDR_W
  - the RGB332 field positions shared with the VGA reader
- One natural sub-module: psdram_addr_counter (frame word counter with clear, increment, wrap and frame_done generation).
- FSM and bus drive stay in the top.

Test Plan:
- Reset low mid-WRITE -> MemWR, RamCE, MemOE = 1 and MemDataOe=0 within the same timestep. After release, the first accepted word goes to address 0.
- Single word 16'hE31C, bus_grant=1 -> SETUP cycle with MemAdr=0 and data driven, then MemWR=0 for exactly 7 clocks, then 1 HOLD clock, then pix_ready high again 10 clocks after acceptance. The PSDRAM model holds E31C at address 0.
- Continuous pix_valid for 641 words -> word 640 lands at MemAdr=640 (line 1, word 0). Acceptances are exactly 10 clocks apart.
- Stream 307200 words -> frame_done single pulse after the write to address 307199; the next word is written at address 0.
- frame_start asserted during WRITE of address 1234 -> 1234 completes; the next word goes to 0 with no frame_done. frame_start coincident with a transfer -> that word is written at 0.
- bus_grant=0 with pix_valid=1 -> bus_req=1, pix_ready=0, no cycle. Grant dropped mid-WRITE -> cycle still completes. With PSDRAM_BYTE_WRITE_EN and be=2'b01 -> RamLB=0, RamUB=1, and only the low byte changes.
